prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/prefetch_fifo.sv | 86 ++++++++
 rtl/prefetch_unit.sv | 135 +++++++++++++
 tb/tb_prefetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default widths, reset fetch address and the
// prefetch controller state encoding.
package cpu_pkg;

  localparam int          ADDR_WIDTH_DEF = 12;
  localparam int          DATA_WIDTH_DEF = 16;
  localparam logic [11:0] RESET_PC_DEF   = 12'h100;

  // IDLE: nothing outstanding, REQ: request in flight whose data is wanted,
  // DRAIN: request in flight whose data must be thrown away.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } pf_state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous instruction buffer with single-cycle flush and occupancy count.
// A push into a full buffer is accepted only when a pop frees a slot in the
// same cycle; a pop from an empty buffer is ignored.
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        valid_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE = CW'(32'd1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(32'd1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != '0);
    push_ok_s = push_i && ((count_q != DEPTH_C) || pop_ok_s);
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: keeps a small buffer of sequential instruction
// words ahead of the CPU, one memory read in flight at a time, and flushes
// and refetches on a redirect. A read abandoned by a redirect is drained
// (its data discarded) before the next read is issued.
module prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int                    CW         = cnt_width(DEPTH);
  localparam int                    EW         = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(32'd2);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(32'd1);

  pf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_d;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic [ADDR_WIDTH-1:0] redir_pc_s;
  logic                  space_s;
  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         fifo_wdata_s;
  logic [EW-1:0]         fifo_rdata_s;
  logic                  fifo_valid_s;
  logic [CW-1:0]         fifo_count_s;

  // Datapath glue: aligned redirect target, next sequential PC, and the
  // buffer push/pop qualifiers. A redirect suppresses both push and pop.
  always_comb begin
    redir_pc_s   = redirect_pc & ALIGN_MASK;
    fetch_pc_d   = fetch_pc_q + PC_STEP;
    space_s      = (fifo_count_s < DEPTH_C);
    push_s       = (state_q == ST_REQ) && mem_ack && !redirect;
    pop_s        = instr_ready && fifo_valid_s && !redirect;
    fifo_wdata_s = {mem_rdata, mem_addr_q};
  end

  // Fetch controller: issues reads, tracks the outstanding one and decides
  // whether its data is kept or drained. Issue is only considered in IDLE,
  // where nothing is outstanding, so buffered count alone bounds the issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redir_pc_s;
          end else if (space_s) begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (redirect) begin
            fetch_pc_q <= redir_pc_s;
            mem_req_q  <= 1'b0;
            state_q    <= mem_ack ? ST_IDLE : ST_DRAIN;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            fetch_pc_q <= redir_pc_s;
          end else begin
            fetch_pc_q <= fetch_pc_q;
          end
          if (mem_ack) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  prefetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push_s),
    .wdata_i (fifo_wdata_s),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .valid_o (fifo_valid_s),
    .count_o (fifo_count_s)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = fifo_valid_s;
  assign instr       = fifo_rdata_s[EW-1:ADDR_WIDTH];
  assign instr_pc    = fifo_rdata_s[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: a latency-programmable memory model, a scoreboard
// holding the instruction stream the CPU must see after each reset/redirect,
// directed scenarios for the key corner cases and a randomized phase.
module tb_prefetch_unit;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        instr_valid;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int          lat    = 1;
  exp_t        exp_q[$];
  logic [11:0] req_log[$];

  prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  function automatic logic [15:0] fdata(input logic [11:0] a);
    return {a[3:0], a} ^ 16'hA5C3;
  endfunction

  // Reference: after a reset/redirect to t, the CPU sees t, t+2, t+4 ... (mod 4096).
  function automatic void start_stream(input logic [11:0] t);
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [11:0] a;
      a = t + 12'(2 * i);
      exp_q.push_back({a, fdata(a)});
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_next(input int n, output logic [11:0] a);
    a = 12'hBAD;
    for (int i = 0; i < 80; i++) begin
      if (req_log.size() > n) begin
        a = req_log[n];
        return;
      end
      cyc();
    end
    chk("req_timeout", 32'(req_log.size()), 32'(n + 1));
  endtask

  task automatic wait_req_high();
    for (int i = 0; i < 80; i++) begin
      if (mem_req) return;
      cyc();
    end
    chk("mem_req_timeout", 32'(mem_req), 32'd1);
  endtask

  // Memory model: latches a request, acks it lat cycles later even if the
  // requester has dropped it, and flags overlapping or unstable requests.
  logic        m_busy = 1'b0;
  logic        m_held = 1'b0;
  logic [11:0] m_addr = 12'h000;
  int          m_cnt  = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_busy    = 1'b0;
      m_held    = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
    end else if (m_busy) begin
      chk("one_outstanding", 32'(mem_req & ~m_held), 32'd0);
      if (mem_req && m_held) chk("mem_addr_stable", 32'(mem_addr), 32'(m_addr));
      if (!mem_req) m_held = 1'b0;
      m_cnt--;
      if (m_cnt <= 0) begin
        mem_ack   = 1'b1;
        mem_rdata = fdata(m_addr);
        m_busy    = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (mem_req) begin
        m_busy = 1'b1;
        m_held = 1'b1;
        m_addr = mem_addr;
        m_cnt  = lat;
      end
    end
  end

  // Monitor: logs new requests and compares every consumed instruction
  // against the scoreboard head.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst && mem_req && !prev_req) req_log.push_back(mem_addr);
    prev_req = mem_req;
    if (!rst && !redirect && instr_valid && instr_ready) begin
      pops++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr_pc", 32'(instr_pc), 32'(e.pc));
        chk("instr", 32'(instr), 32'(e.data));
      end
    end
  end

  initial begin
    logic [11:0] a;
    int          n;
    int          p0;
    int          r;

    // Reset values
    start_stream(12'h100);
    cyc();
    cyc();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h100);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Fill with latency 1 and no consumption: exactly four requests
    lat = 1;
    req_log.delete();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cyc();
    chk("fill_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (req_log.size() > i) chk("fill_addr", 32'(req_log[i]), 32'(12'h100 + 12'(2 * i)));
    end
    chk("fill_mem_req_idle", 32'(mem_req), 32'd0);
    chk("fill_valid", 32'(instr_valid), 32'd1);

    // Pop one, let 'h108 go out, redirect to 'h116 while it is pending
    lat = 6;
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    wait_req_high();
    chk("pending_addr", 32'(mem_addr), 32'h108);
    redirect = 1'b1;
    redirect_pc = 12'h116;
    start_stream(12'h116);
    cyc();
    redirect = 1'b0;
    chk("redir_valid_low", 32'(instr_valid), 32'd0);
    chk("drain_mem_req_low", 32'(mem_req), 32'd0);
    n = req_log.size();
    wait_next(n, a);
    chk("after_drain_addr", 32'(a), 32'h116);
    instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    instr_ready = 1'b0;

    // Odd redirect target is aligned down
    lat = 2;
    redirect = 1'b1;
    redirect_pc = 12'h123;
    start_stream(12'h122);
    cyc();
    redirect = 1'b0;
    n = req_log.size();
    wait_next(n, a);
    chk("odd_redirect_addr", 32'(a), 32'h122);

    // Wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 12'hFFE;
    start_stream(12'hFFE);
    cyc();
    redirect = 1'b0;
    n = req_log.size();
    wait_next(n, a);
    chk("wrap_first", 32'(a), 32'hFFE);
    wait_next(n + 1, a);
    chk("wrap_second", 32'(a), 32'h000);
    instr_ready = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    instr_ready = 1'b0;

    // Reset while a request is outstanding
    wait_req_high();
    rst = 1'b1;
    start_stream(12'h100);
    cyc();
    chk("midreq_rst_mem_req", 32'(mem_req), 32'd0);
    chk("midreq_rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    n = req_log.size();
    wait_next(n, a);
    chk("post_rst_addr", 32'(a), 32'h100);

    // Continuous consumption with latency 3
    lat = 3;
    instr_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 200; i++) cyc();
    chk("stream_progress", 32'(pops - p0 >= 30), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      instr_ready = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 4);
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1'b1;
        redirect = 1'b0;
        start_stream(12'h100);
      end else begin
        rst = 1'b0;
        if (r < 10) begin
          redirect = 1'b1;
          redirect_pc = 12'($urandom);
          start_stream(redirect_pc & 12'hFFE);
        end else begin
          redirect = 1'b0;
        end
      end
      cyc();
    end
    rst = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
